// File: rtl/sprite_commit_sched_pkg.sv
// Shared constants, types and clamp helpers for the sprite commit scheduler.
package sprite_commit_sched_pkg;

  localparam int unsigned OBJ_PLAYER = 0;
  localparam int unsigned OBJ_ENEMY  = 1;
  localparam int unsigned OBJ_BULLET = 2;
  localparam int unsigned N_OBJ      = 3;
  localparam int unsigned IDX_W      = 2;

  localparam int unsigned X_W = 10;
  localparam int unsigned Y_W = 9;

  localparam int unsigned X_MIN_DEF = 11;
  localparam int unsigned X_MAX_DEF = 619;
  localparam int unsigned Y_MIN_DEF = 11;
  localparam int unsigned Y_MAX_DEF = 459;

  typedef enum logic [0:0] {
    ST_ARB    = 1'b0,
    ST_COMMIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [Y_W-1:0] y;
    logic [X_W-1:0] x;
  } pos_t;

  function automatic logic [X_W-1:0] clamp_x(input logic [X_W-1:0] v,
                                             input logic [X_W-1:0] lo,
                                             input logic [X_W-1:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [Y_W-1:0] clamp_y(input logic [Y_W-1:0] v,
                                             input logic [Y_W-1:0] lo,
                                             input logic [Y_W-1:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/sprite_commit_sched_rr_arb3.sv
// Three-way round-robin arbiter; the pointer advances past the winner when adv_i is high.
module rr_arb3
  import sprite_commit_sched_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             adv_i,
  input  logic [N_OBJ-1:0] req_i,
  output logic [N_OBJ-1:0] gnt_c_o,
  output logic [IDX_W-1:0] idx_c_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan requesters starting at the pointer, first hit wins.
  always_comb begin
    gnt_c_o = '0;
    idx_c_o = '0;
    sum     = '0;
    cand    = '0;
    found   = 1'b0;
    for (int k = 0; k < int'(N_OBJ); k++) begin
      sum  = (IDX_W+1)'(ptr_q) + (IDX_W+1)'(k);
      cand = (sum >= (IDX_W+1)'(N_OBJ)) ? IDX_W'(sum - (IDX_W+1)'(N_OBJ)) : IDX_W'(sum);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        gnt_c_o[cand] = 1'b1;
        idx_c_o       = cand;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (adv_i && found) begin
      ptr_q <= (idx_c_o == IDX_W'(N_OBJ - 1)) ? '0 : idx_c_o + IDX_W'(1);
    end
  end

endmodule

// File: rtl/sprite_commit_sched.sv
// Arbitrates object position writes into shadow registers and commits them to
// the renderer-facing registers at vertical-blank start; also divides frames into game ticks.
module sprite_commit_sched
  import sprite_commit_sched_pkg::*;
#(
  parameter int unsigned X_MIN           = X_MIN_DEF,
  parameter int unsigned X_MAX           = X_MAX_DEF,
  parameter int unsigned Y_MIN           = Y_MIN_DEF,
  parameter int unsigned Y_MAX           = Y_MAX_DEF,
  parameter int unsigned FRAMES_PER_TICK = 2
) (
  input  logic                 master_clk,
  input  logic                 reset,
  input  logic                 vblank_start,
  input  logic [N_OBJ-1:0]     req,
  input  logic [N_OBJ*X_W-1:0] req_x,
  input  logic [N_OBJ*Y_W-1:0] req_y,
  output logic [N_OBJ-1:0]     grant,
  output logic [X_W-1:0]       playerX,
  output logic [X_W-1:0]       enemyX,
  output logic [X_W-1:0]       bulletX,
  output logic [Y_W-1:0]       playerY,
  output logic [Y_W-1:0]       enemyY,
  output logic [Y_W-1:0]       bulletY,
  output logic [N_OBJ-1:0]     dirty,
  output logic                 commit,
  output logic                 game_tick,
  output logic [7:0]           frame_count
);

  localparam int unsigned DIV_W = 8;
  localparam pos_t RESET_POS = '{y: Y_W'(Y_MIN), x: X_W'(X_MIN)};

  state_e           state_q;
  logic [N_OBJ-1:0] grant_q;
  logic [N_OBJ-1:0] dirty_q;
  logic             commit_q;
  logic             tick_q;
  logic [7:0]       frame_q;
  logic [DIV_W-1:0] div_q;
  pos_t             shadow_q [N_OBJ];
  pos_t             active_q [N_OBJ];

  pos_t             req_pos_c [N_OBJ];
  pos_t             sel_pos_c;
  logic [N_OBJ-1:0] arb_req_c;
  logic [N_OBJ-1:0] gnt_c;
  logic [IDX_W-1:0] idx_c;
  logic             adv_c;

  // A requester seeing its grant this cycle is already served; mask it so it is not granted twice.
  assign arb_req_c = req & ~grant_q;
  assign adv_c     = (state_q == ST_ARB) && !vblank_start;

  rr_arb3 u_arb (
    .clk_i   (master_clk),
    .rst_i   (reset),
    .adv_i   (adv_c),
    .req_i   (arb_req_c),
    .gnt_c_o (gnt_c),
    .idx_c_o (idx_c)
  );

  always_comb begin
    for (int i = 0; i < int'(N_OBJ); i++) begin
      req_pos_c[i].x = req_x[i*X_W +: X_W];
      req_pos_c[i].y = req_y[i*Y_W +: Y_W];
    end
    sel_pos_c.x = clamp_x(req_pos_c[idx_c].x, X_W'(X_MIN), X_W'(X_MAX));
    sel_pos_c.y = clamp_y(req_pos_c[idx_c].y, Y_W'(Y_MIN), Y_W'(Y_MAX));
  end

  always_ff @(posedge master_clk) begin
    if (reset) begin
      state_q  <= ST_ARB;
      grant_q  <= '0;
      dirty_q  <= '0;
      commit_q <= 1'b0;
      tick_q   <= 1'b0;
      frame_q  <= '0;
      div_q    <= '0;
      for (int i = 0; i < int'(N_OBJ); i++) begin
        shadow_q[i] <= RESET_POS;
        active_q[i] <= RESET_POS;
      end
    end else begin
      grant_q  <= '0;
      commit_q <= 1'b0;
      tick_q   <= 1'b0;
      case (state_q)
        ST_ARB: begin
          if (vblank_start) begin
            state_q <= ST_COMMIT;
          end else if (|gnt_c) begin
            grant_q         <= gnt_c;
            shadow_q[idx_c] <= sel_pos_c;
            dirty_q[idx_c]  <= 1'b1;
          end
        end
        ST_COMMIT: begin
          for (int i = 0; i < int'(N_OBJ); i++) begin
            if (dirty_q[i]) active_q[i] <= shadow_q[i];
          end
          dirty_q  <= '0;
          commit_q <= 1'b1;
          frame_q  <= frame_q + 8'd1;
          if (div_q == DIV_W'(FRAMES_PER_TICK - 1)) begin
            div_q  <= '0;
            tick_q <= 1'b1;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
          state_q <= ST_ARB;
        end
        default: state_q <= ST_ARB;
      endcase
    end
  end

  assign grant       = grant_q;
  assign dirty       = dirty_q;
  assign commit      = commit_q;
  assign game_tick   = tick_q;
  assign frame_count = frame_q;
  assign playerX     = active_q[OBJ_PLAYER].x;
  assign playerY     = active_q[OBJ_PLAYER].y;
  assign enemyX      = active_q[OBJ_ENEMY].x;
  assign enemyY      = active_q[OBJ_ENEMY].y;
  assign bulletX     = active_q[OBJ_BULLET].x;
  assign bulletY     = active_q[OBJ_BULLET].y;

endmodule

// File: tb/tb_sprite_commit_sched.sv
// Scoreboard bench for sprite_commit_sched: grants and committed snapshots are predicted at stimulus time.
module tb_sprite_commit_sched;

  localparam int FPT = 2;

  logic        master_clk = 1'b0;
  logic        reset = 1'b1;
  logic        vblank_start = 1'b0;
  logic [2:0]  req = '0;
  logic [29:0] req_x = '0;
  logic [26:0] req_y = '0;
  logic [2:0]  grant;
  logic [9:0]  playerX, enemyX, bulletX;
  logic [8:0]  playerY, enemyY, bulletY;
  logic [2:0]  dirty;
  logic        commit;
  logic        game_tick;
  logic [7:0]  frame_count;

  sprite_commit_sched #(.FRAMES_PER_TICK(FPT)) dut (
    .master_clk   (master_clk),
    .reset        (reset),
    .vblank_start (vblank_start),
    .req          (req),
    .req_x        (req_x),
    .req_y        (req_y),
    .grant        (grant),
    .playerX      (playerX),
    .enemyX       (enemyX),
    .bulletX      (bulletX),
    .playerY      (playerY),
    .enemyY       (enemyY),
    .bulletY      (bulletY),
    .dirty        (dirty),
    .commit       (commit),
    .game_tick    (game_tick),
    .frame_count  (frame_count)
  );

  always #5 master_clk = ~master_clk;

  typedef struct packed {
    logic            tick;
    logic [7:0]      frame;
    logic [2:0][8:0] y;
    logic [2:0][9:0] x;
  } snap_t;

  snap_t obs;
  always_comb begin
    obs.tick  = game_tick;
    obs.frame = frame_count;
    obs.x[0]  = playerX;  obs.x[1] = enemyX;  obs.x[2] = bulletX;
    obs.y[0]  = playerY;  obs.y[1] = enemyY;  obs.y[2] = bulletY;
  end

  logic [2:0] gnt_sb[$];
  snap_t      commit_sb[$];
  logic [2:0][9:0] m_ax, m_sx;
  logic [2:0][8:0] m_ay, m_sy;
  logic [2:0] m_dirty;
  int m_div, m_frames;
  int n_cmp = 0;
  int n_err = 0;

  task automatic step();
    @(posedge master_clk);
    #1;
  endtask

  function automatic logic [9:0] bclamp_x(input int v);
    return (v < 11) ? 10'd11 : (v > 619) ? 10'd619 : 10'(v);
  endfunction

  function automatic logic [8:0] bclamp_y(input int v);
    return (v < 11) ? 9'd11 : (v > 459) ? 9'd459 : 9'(v);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 3; i++) begin
      m_ax[i] = 10'd11; m_ay[i] = 9'd11; m_sx[i] = 10'd11; m_sy[i] = 9'd11;
    end
    m_dirty = '0; m_div = 0; m_frames = 0;
    gnt_sb.delete(); commit_sb.delete();
  endfunction

  function automatic void m_write(input int i, input int x, input int y);
    m_sx[i] = bclamp_x(x); m_sy[i] = bclamp_y(y); m_dirty[i] = 1'b1;
  endfunction

  function automatic void m_commit();
    snap_t s;
    for (int i = 0; i < 3; i++) begin
      if (m_dirty[i]) begin m_ax[i] = m_sx[i]; m_ay[i] = m_sy[i]; end
    end
    m_dirty  = '0;
    m_frames = (m_frames + 1) % 256;
    s.tick   = (m_div == FPT - 1);
    m_div    = s.tick ? 0 : m_div + 1;
    s.frame  = 8'(m_frames);
    s.x = m_ax; s.y = m_ay;
    commit_sb.push_back(s);
  endfunction

  task automatic drive_req(input int i, input int x, input int y);
    req[i] = 1'b1;
    req_x[10*i +: 10] = 10'(x);
    req_y[9*i +: 9]   = 9'(y);
  endtask

  task automatic apply_reset();
    reset = 1'b1; req = '0; vblank_start = 1'b0;
    step(); step();
    m_reset();
    reset = 1'b0;
  endtask

  // Waits (bounded) for the commit pulse; leaves time in the commit cycle.
  task automatic wait_commit(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (commit === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; vblank_start = 1'b0;
    step(); step();
    m_reset();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs.x[i] !== 10'd11 || obs.y[i] !== 9'd11) begin
        n_err++; $display("FAIL reset_pos%0d: got %0d/%0d expected 11/11", i, obs.x[i], obs.y[i]);
      end
    end
    n_cmp++;
    if ({grant, dirty, commit, game_tick, frame_count} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_ctrl: got grant=%b dirty=%b commit=%b tick=%b frame=%0d expected all zero",
               grant, dirty, commit, game_tick, frame_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_update();
    logic [2:0] eg;
    snap_t es;
    bit ok;
    drive_req(0, 100, 200); m_write(0, 100, 200); gnt_sb.push_back(3'b001);
    step();
    eg = gnt_sb.pop_front(); n_cmp++;
    if (grant !== eg) begin n_err++; $display("FAIL single_grant: got %b expected %b", grant, eg); end
    req = '0;
    n_cmp++;
    if (dirty !== m_dirty) begin n_err++; $display("FAIL single_dirty: got %b expected %b", dirty, m_dirty); end
    n_cmp++;
    if (playerX !== 10'd11 || playerY !== 9'd11) begin
      n_err++; $display("FAIL single_precommit: got %0d/%0d expected 11/11", playerX, playerY);
    end
    vblank_start = 1'b1; m_commit();
    step();
    vblank_start = 1'b0;
    n_cmp++;
    if (playerX !== 10'd11) begin n_err++; $display("FAIL single_early: got %0d expected 11", playerX); end
    wait_commit(ok);
    es = commit_sb.pop_front(); n_cmp++;
    if (!ok) begin n_err++; $display("FAIL single_commit_timeout: got no commit expected commit pulse"); end
    else if (obs !== es) begin n_err++; $display("FAIL single_snapshot: got %h expected %h", obs, es); end
    n_cmp++;
    if (dirty !== 3'b000) begin n_err++; $display("FAIL single_dirty_clr: got %b expected 000", dirty); end
  endtask

  task automatic test_round_robin();
    logic [2:0] eg;
    snap_t es;
    bit ok;
    apply_reset();
    for (int i = 0; i < 3; i++) begin drive_req(i, 50 + 10*i, 60 + 10*i); m_write(i, 50 + 10*i, 60 + 10*i); end
    gnt_sb.push_back(3'b001); gnt_sb.push_back(3'b010); gnt_sb.push_back(3'b100);
    for (int k = 0; k < 3; k++) begin
      step();
      eg = gnt_sb.pop_front(); n_cmp++;
      if (grant !== eg) begin n_err++; $display("FAIL rr_first%0d: got %b expected %b", k, grant, eg); end
      req = req & ~grant;
    end
    drive_req(0, 400, 300); drive_req(1, 500, 350);
    m_write(0, 400, 300); m_write(1, 500, 350);
    gnt_sb.push_back(3'b001); gnt_sb.push_back(3'b010);
    for (int k = 0; k < 2; k++) begin
      step();
      eg = gnt_sb.pop_front(); n_cmp++;
      if (grant !== eg) begin n_err++; $display("FAIL rr_wrap%0d: got %b expected %b", k, grant, eg); end
      req = req & ~grant;
    end
    step();
    n_cmp++;
    if (grant !== 3'b000) begin n_err++; $display("FAIL rr_idle: got %b expected 000", grant); end
    vblank_start = 1'b1; m_commit();
    step();
    vblank_start = 1'b0;
    wait_commit(ok);
    es = commit_sb.pop_front(); n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rr_commit_timeout: got no commit expected commit pulse"); end
    else if (obs !== es) begin n_err++; $display("FAIL rr_last_write: got %h expected %h", obs, es); end
  endtask

  task automatic test_clamp();
    logic [2:0] eg;
    snap_t es;
    bit ok;
    int cx[3] = '{1023, 0, 700};
    int cy[3] = '{459, 470, 5};
    for (int i = 2; i >= 0; i--) begin
      req = '0;
      drive_req(i, cx[i], cy[i]); m_write(i, cx[i], cy[i]);
      gnt_sb.push_back(3'(1 << i));
      step();
      eg = gnt_sb.pop_front(); n_cmp++;
      if (grant !== eg) begin n_err++; $display("FAIL clamp_grant%0d: got %b expected %b", i, grant, eg); end
    end
    req = '0;
    vblank_start = 1'b1; m_commit();
    step();
    vblank_start = 1'b0;
    wait_commit(ok);
    es = commit_sb.pop_front(); n_cmp++;
    if (!ok) begin n_err++; $display("FAIL clamp_commit_timeout: got no commit expected commit pulse"); end
    else if (obs !== es) begin n_err++; $display("FAIL clamp_snapshot: got %h expected %h", obs, es); end
    n_cmp++;
    if (bulletX !== 10'd619 || bulletY !== 9'd11 || enemyX !== 10'd11 || enemyY !== 9'd459 || playerX !== 10'd619) begin
      n_err++;
      $display("FAIL clamp_values: got b=%0d/%0d e=%0d/%0d pX=%0d expected b=619/11 e=11/459 pX=619",
               bulletX, bulletY, enemyX, enemyY, playerX);
    end
  endtask

  task automatic test_collision();
    logic [2:0] eg;
    snap_t es;
    req = '0;
    drive_req(1, 300, 300);
    vblank_start = 1'b1; m_commit();
    gnt_sb.push_back(3'b010); m_write(1, 300, 300);
    step();
    vblank_start = 1'b0;
    n_cmp++;
    if (grant !== 3'b000) begin n_err++; $display("FAIL coll_nogrant: got %b expected 000", grant); end
    step();
    es = commit_sb.pop_front(); n_cmp++;
    if (commit !== 1'b1 || grant !== 3'b000 || obs !== es) begin
      n_err++; $display("FAIL coll_commit: got c=%b g=%b %h expected c=1 g=000 %h", commit, grant, obs, es);
    end
    step();
    eg = gnt_sb.pop_front(); n_cmp++;
    if (grant !== eg) begin n_err++; $display("FAIL coll_late_grant: got %b expected %b", grant, eg); end
    req = '0;
    vblank_start = 1'b1; m_commit();
    step(); step();
    vblank_start = 1'b0;
    es = commit_sb.pop_front(); n_cmp++;
    if (commit !== 1'b1 || obs !== es) begin
      n_err++; $display("FAIL coll_next_frame: got c=%b %h expected c=1 %h", commit, obs, es);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++;
      if (commit !== 1'b0) begin n_err++; $display("FAIL coll_no_b2b%0d: got %b expected 0", k, commit); end
    end
  endtask

  task automatic test_tick_wrap();
    snap_t es;
    bit ok;
    int ticks = 0;
    int stray = 0;
    apply_reset();
    for (int n = 0; n < 256; n++) begin
      vblank_start = 1'b1; m_commit();
      step();
      vblank_start = 1'b0;
      if (game_tick !== 1'b0) stray++;
      wait_commit(ok);
      es = commit_sb.pop_front(); n_cmp++;
      if (!ok) begin n_err++; $display("FAIL tick_commit_timeout%0d: got no commit expected commit pulse", n); end
      else if (obs !== es) begin n_err++; $display("FAIL tick_frame%0d: got %h expected %h", n, obs, es); end
      if (game_tick === 1'b1) ticks++;
    end
    n_cmp++;
    if (ticks != 128) begin n_err++; $display("FAIL tick_count: got %0d expected 128", ticks); end
    n_cmp++;
    if (stray != 0) begin n_err++; $display("FAIL tick_stray: got %0d expected 0", stray); end
    n_cmp++;
    if (frame_count !== 8'd0) begin n_err++; $display("FAIL frame_wrap: got %0d expected 0", frame_count); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] eg;
    snap_t es;
    bit ok;
    req = '0;
    drive_req(0, 200, 150); m_write(0, 200, 150); gnt_sb.push_back(3'b001);
    step();
    eg = gnt_sb.pop_front(); n_cmp++;
    if (grant !== eg) begin n_err++; $display("FAIL rmid_pre_grant: got %b expected %b", grant, eg); end
    req = '0;
    drive_req(2, 400, 300);
    reset = 1'b1;
    step();
    m_reset();
    n_cmp++;
    if (grant !== 3'b000 || dirty !== 3'b000 || frame_count !== 8'd0) begin
      n_err++; $display("FAIL rmid_ctrl: got g=%b d=%b f=%0d expected 000/000/0", grant, dirty, frame_count);
    end
    n_cmp++;
    if (bulletX !== 10'd11 || playerX !== 10'd11 || playerY !== 9'd11) begin
      n_err++; $display("FAIL rmid_pos: got b=%0d p=%0d/%0d expected 11 11/11", bulletX, playerX, playerY);
    end
    reset = 1'b0; req = '0;
    vblank_start = 1'b1; m_commit();
    step();
    vblank_start = 1'b0;
    wait_commit(ok);
    es = commit_sb.pop_front(); n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rmid_commit_timeout: got no commit expected commit pulse"); end
    else if (obs !== es) begin n_err++; $display("FAIL rmid_shadow: got %h expected %h", obs, es); end
  endtask

  initial begin
    test_reset();
    test_single_update();
    test_round_robin();
    test_clamp();
    test_collision();
    test_tick_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
